// File: rtl/enemy_director.sv
// Level-wide enemy controller: spawn scheduling from scroll position, alert/game-over FSM,
// and lowest-index arbitration of the shared enemy sprite ROM address.
module enemy_director #(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter logic [15:0] SPAWN_BASE   = 16'd650,
  parameter logic [15:0] SPAWN_STEP   = 16'd640,
  parameter logic [7:0]  GRACE_FRAMES = 8'd30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        level_start,
  input  logic [15:0] bg_position,
  input  logic [3:0]  enemy_alive,
  input  logic [3:0]  enemy_detect,
  input  logic [3:0]  is_enemy,
  input  logic [63:0] enemy_addr_flat,
  output logic [3:0]  spawn,
  output logic        alarm,
  output logic        game_over,
  output logic        level_clear,
  output logic [2:0]  enemies_left,
  output logic        is_enemy_any,
  output logic [15:0] sprite_addr,
  output logic [1:0]  sprite_sel,
  output logic [2:0]  state_out
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PATROL   = 3'd1,
    ALERT    = 3'd2,
    GAMEOVER = 3'd3,
    CLEAR    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         spawn_c;
  logic               spawn_found;
  logic               fc_meta, fc_sync, fc_prev;
  logic               fe;
  logic [3:0]         live;
  logic               clear_c, det_c;
  logic [2:0]         left_c;
  logic               hit_c;
  logic [SEL_W-1:0]   sel_c;
  logic [ADDR_W-1:0]  addr_c;

  // Thresholds are formed wider than bg_position so a large slot offset never wraps.
  function automatic logic [31:0] spawn_thr(input int unsigned idx);
    return 32'(SPAWN_BASE) + idx * 32'(SPAWN_STEP);
  endfunction

  assign fe        = fc_sync & ~fc_prev;
  assign live      = mask_q & enemy_alive;
  assign clear_c   = (mask_q == 4'b1111) && (live == 4'b0000);
  assign det_c     = |(enemy_detect & live);
  assign state_out = 3'(state_q);

  // Next-state, spawn selection and grace counter
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    spawn_c     = '0;
    spawn_found = 1'b0;
    if (level_start) begin
      state_d = PATROL;
      mask_d  = '0;
      cnt_d   = '0;
    end else begin
      if (fe && (state_q == PATROL || state_q == ALERT)) begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (!spawn_found && !mask_q[i] && (32'(bg_position) >= spawn_thr(i))) begin
            spawn_found = 1'b1;
            spawn_c[i]  = 1'b1;
            mask_d[i]   = 1'b1;
          end
        end
      end
      case (state_q)
        PATROL: begin
          if (clear_c) begin
            state_d = CLEAR;
          end else if (det_c) begin
            state_d = ALERT;
            cnt_d   = GRACE_FRAMES;
          end
        end
        ALERT: begin
          if (clear_c) begin
            state_d = CLEAR;
          end else if (fe) begin
            if (!det_c) begin
              state_d = PATROL;
            end else if (cnt_q <= CNT_W'(1)) begin
              state_d = GAMEOVER;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Live-enemy population count
  always_comb begin
    left_c = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      left_c = left_c + 3'(live[i]);
    end
  end

  // Descending scan so the lowest requesting index is the final assignment
  always_comb begin
    hit_c  = 1'b0;
    sel_c  = '0;
    addr_c = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (is_enemy[i]) begin
        hit_c  = 1'b1;
        sel_c  = SEL_W'(i);
        addr_c = enemy_addr_flat[ADDR_W*i +: ADDR_W];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fc_meta      <= 1'b0;
      fc_sync      <= 1'b0;
      fc_prev      <= 1'b0;
      state_q      <= IDLE;
      mask_q       <= '0;
      cnt_q        <= '0;
      spawn        <= '0;
      alarm        <= 1'b0;
      game_over    <= 1'b0;
      level_clear  <= 1'b0;
      enemies_left <= '0;
      is_enemy_any <= 1'b0;
      sprite_sel   <= '0;
      sprite_addr  <= '0;
    end else begin
      fc_meta      <= frame_clk;
      fc_sync      <= fc_meta;
      fc_prev      <= fc_sync;
      state_q      <= state_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      spawn        <= spawn_c;
      alarm        <= (state_d == ALERT);
      game_over    <= (state_d == GAMEOVER);
      level_clear  <= (state_d == CLEAR);
      enemies_left <= left_c;
      is_enemy_any <= hit_c;
      sprite_sel   <= sel_c;
      sprite_addr  <= addr_c;
    end
  end

endmodule

// File: tb/tb_enemy_director.sv
// Directed bench for enemy_director; stimulus queues expectations, one monitor checks them.
`timescale 1ns/1ps
module tb_enemy_director;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PATROL   = 3'd1;
  localparam logic [2:0] S_ALERT    = 3'd2;
  localparam logic [2:0] S_GAMEOVER = 3'd3;
  localparam logic [2:0] S_CLEAR    = 3'd4;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic        level_start;
  logic [15:0] bg_position;
  logic [3:0]  enemy_alive;
  logic [3:0]  enemy_detect;
  logic [3:0]  is_enemy;
  logic [63:0] enemy_addr_flat;
  logic [3:0]  spawn;
  logic        alarm;
  logic        game_over;
  logic        level_clear;
  logic [2:0]  enemies_left;
  logic        is_enemy_any;
  logic [15:0] sprite_addr;
  logic [1:0]  sprite_sel;
  logic [2:0]  state_out;

  typedef struct packed {
    logic [2:0] st;
    logic       al;
    logic       go;
    logic       lc;
    logic [2:0] left;
  } snap_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [31:0] cyc;
  } arb_t;

  snap_t      snap_q[$];
  string      name_q[$];
  logic [3:0] spawn_q[$];
  arb_t       arb_q[$];
  logic       rst_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic done     = 1'b0;
  logic finished = 1'b0;

  enemy_director dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_clk       (frame_clk),
    .level_start     (level_start),
    .bg_position     (bg_position),
    .enemy_alive     (enemy_alive),
    .enemy_detect    (enemy_detect),
    .is_enemy        (is_enemy),
    .enemy_addr_flat (enemy_addr_flat),
    .spawn           (spawn),
    .alarm           (alarm),
    .game_over       (game_over),
    .level_clear     (level_clear),
    .enemies_left    (enemies_left),
    .is_enemy_any    (is_enemy_any),
    .sprite_addr     (sprite_addr),
    .sprite_sel      (sprite_sel),
    .state_out       (state_out)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required end of stimulus");
    $fatal(1);
  end

  // Monitor: spawn pulses, arbitration results, reset snapshots and state probes
  always @(negedge Clk) begin
    snap_t      es;
    string      nm;
    logic [3:0] esp;
    arb_t       ea;
    logic       rdummy;
    if (rst_q.size() > 0 && Reset === 1'b0) begin
      rdummy = rst_q.pop_front();
      n_checks++;
      if ({spawn, state_out, alarm, game_over, level_clear, enemies_left,
           is_enemy_any, sprite_sel, sprite_addr} !== '0) begin
        n_fail++;
        $display("FAIL async_reset: got spawn=%b st=%0d al=%b go=%b lc=%b left=%0d any=%b sel=%0d addr=%h, required all 0",
                 spawn, state_out, alarm, game_over, level_clear, enemies_left,
                 is_enemy_any, sprite_sel, sprite_addr);
      end
    end
    if (spawn !== 4'b0000) begin
      n_checks++;
      if (spawn_q.size() == 0) begin
        n_fail++;
        $display("FAIL spawn_unexpected: got %b at cycle %0d, required no spawn", spawn, cyc);
      end else begin
        esp = spawn_q.pop_front();
        if (spawn !== esp) begin
          n_fail++;
          $display("FAIL spawn_order: got %b, required %b", spawn, esp);
        end
      end
    end
    if (is_enemy_any !== 1'b0) begin
      n_checks++;
      if (arb_q.size() == 0) begin
        n_fail++;
        $display("FAIL arb_unexpected: got any=%b sel=%0d addr=%h, required no request", is_enemy_any, sprite_sel, sprite_addr);
      end else begin
        ea = arb_q.pop_front();
        if (is_enemy_any !== 1'b1 || sprite_sel !== ea.sel || sprite_addr !== ea.addr || 32'(cyc) !== ea.cyc) begin
          n_fail++;
          $display("FAIL arb_winner: got sel=%0d addr=%h cycle=%0d, required sel=%0d addr=%h cycle=%0d",
                   sprite_sel, sprite_addr, cyc, ea.sel, ea.addr, ea.cyc);
        end
      end
    end
    while (snap_q.size() > 0) begin
      es = snap_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (state_out !== es.st || alarm !== es.al || game_over !== es.go || level_clear !== es.lc ||
          enemies_left !== es.left || is_enemy_any !== 1'b0 || sprite_sel !== 2'd0 || sprite_addr !== 16'h0) begin
        n_fail++;
        $display("FAIL %s: got st=%0d al=%b go=%b lc=%b left=%0d any=%b sel=%0d addr=%h, required st=%0d al=%b go=%b lc=%b left=%0d any=0 sel=0 addr=0000",
                 nm, state_out, alarm, game_over, level_clear, enemies_left, is_enemy_any, sprite_sel, sprite_addr,
                 es.st, es.al, es.go, es.lc, es.left);
      end
    end
    if (done && !finished) begin
      finished = 1'b1;
      n_checks++;
      if (spawn_q.size() != 0) begin
        n_fail++;
        $display("FAIL spawn_missing: got %0d expected spawns never seen, required 0", spawn_q.size());
      end
      n_checks++;
      if (arb_q.size() != 0) begin
        n_fail++;
        $display("FAIL arb_missing: got %0d expected grants never seen, required 0", arb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (5) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic start_level();
    @(posedge Clk); #1 level_start = 1'b1;
    @(posedge Clk); #1 level_start = 1'b0;
  endtask

  task automatic probe(input string nm, input logic [2:0] st, input logic al, input logic go,
                       input logic lc, input logic [2:0] left);
    snap_t s;
    repeat (2) @(posedge Clk);
    #1;
    s.st = st; s.al = al; s.go = go; s.lc = lc; s.left = left;
    snap_q.push_back(s);
    name_q.push_back(nm);
    @(negedge Clk); #1;
  endtask

  task automatic arb(input logic [3:0] req, input logic [1:0] sel, input logic [15:0] addr);
    arb_t a;
    @(posedge Clk); #1 is_enemy = req;
    a.sel = sel; a.addr = addr; a.cyc = 32'(cyc + 1);
    arb_q.push_back(a);
    @(posedge Clk); #1 is_enemy = 4'b0000;
    @(posedge Clk); #1;
  endtask

  initial begin
    Reset           = 1'b0;
    frame_clk       = 1'b0;
    level_start     = 1'b0;
    bg_position     = 16'd0;
    enemy_alive     = 4'b1111;
    enemy_detect    = 4'b0000;
    is_enemy        = 4'b0000;
    enemy_addr_flat = {16'hBEEF, 16'h5678, 16'h1234, 16'h0A0A};
    tick(3);
    Reset = 1'b1;
    probe("idle_after_reset", S_IDLE, 1'b0, 1'b0, 1'b0, 3'd0);
    bg_position = 16'd5000;
    frame();
    probe("idle_no_spawn", S_IDLE, 1'b0, 1'b0, 1'b0, 3'd0);

    // Pixel arbitration
    arb(4'b1010, 2'd1, 16'h1234);
    arb(4'b1000, 2'd3, 16'hBEEF);
    arb(4'b0101, 2'd0, 16'h0A0A);
    arb(4'b1100, 2'd2, 16'h5678);
    probe("arb_no_request", S_IDLE, 1'b0, 1'b0, 1'b0, 3'd0);

    // Spawn scheduling and ignored detect on an unspawned slot
    start_level();
    probe("level_start", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd0);
    bg_position = 16'd650;
    spawn_q.push_back(4'b0001);
    frames(4);
    probe("slot0_spawned", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd1);
    enemy_detect = 4'b0100;
    frame();
    probe("detect_unspawned_ignored", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd1);
    enemy_detect = 4'b0000;
    bg_position = 16'd1930;
    spawn_q.push_back(4'b0010);
    spawn_q.push_back(4'b0100);
    frames(3);
    probe("three_spawned", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd3);
    enemy_alive = 4'b1011;
    probe("left_tracks_alive", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd2);
    enemy_alive = 4'b1111;
    probe("left_restored", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd3);

    // Grace window expiring into game over
    enemy_detect = 4'b0001;
    probe("alert_entry", S_ALERT, 1'b1, 1'b0, 1'b0, 3'd3);
    frames(29);
    probe("alert_after_29", S_ALERT, 1'b1, 1'b0, 1'b0, 3'd3);
    frame();
    probe("gameover_on_30", S_GAMEOVER, 1'b0, 1'b1, 1'b0, 3'd3);
    enemy_detect = 4'b0000;
    frame();
    probe("gameover_sticky", S_GAMEOVER, 1'b0, 1'b1, 1'b0, 3'd3);

    // Detect dropped inside the grace window
    start_level();
    probe("restart", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd0);
    spawn_q.push_back(4'b0001);
    spawn_q.push_back(4'b0010);
    spawn_q.push_back(4'b0100);
    frames(3);
    probe("respawned_three", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd3);
    enemy_detect = 4'b0001;
    probe("alert_again", S_ALERT, 1'b1, 1'b0, 1'b0, 3'd3);
    frames(9);
    probe("alert_after_9", S_ALERT, 1'b1, 1'b0, 1'b0, 3'd3);
    enemy_detect = 4'b0000;
    frame();
    probe("detect_dropped", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd3);

    // Detect from a dead slot
    enemy_alive  = 4'b1110;
    enemy_detect = 4'b0001;
    probe("dead_detect_ignored", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd2);
    frame();
    probe("dead_detect_frame", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd2);
    enemy_detect = 4'b0000;
    enemy_alive  = 4'b1111;

    // Clear beats game over on the final frame edge
    bg_position = 16'd2570;
    spawn_q.push_back(4'b1000);
    frame();
    probe("all_spawned", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd4);
    enemy_detect = 4'b0010;
    probe("alert_all", S_ALERT, 1'b1, 1'b0, 1'b0, 3'd4);
    frames(29);
    probe("alert_before_final", S_ALERT, 1'b1, 1'b0, 1'b0, 3'd4);
    @(posedge Clk); #1 frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #1 enemy_alive = 4'b0000;
    repeat (3) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    probe("clear_beats_gameover", S_CLEAR, 1'b0, 1'b0, 1'b1, 3'd0);
    enemy_detect = 4'b0000;
    frame();
    probe("clear_sticky", S_CLEAR, 1'b0, 1'b0, 1'b1, 3'd0);

    // Asynchronous reset in the middle of ALERT
    enemy_alive = 4'b1111;
    start_level();
    probe("level_three", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd0);
    spawn_q.push_back(4'b0001);
    spawn_q.push_back(4'b0010);
    spawn_q.push_back(4'b0100);
    spawn_q.push_back(4'b1000);
    frames(4);
    probe("four_spawned", S_PATROL, 1'b0, 1'b0, 1'b0, 3'd4);
    enemy_detect = 4'b0001;
    probe("alert_before_reset", S_ALERT, 1'b1, 1'b0, 1'b0, 3'd4);
    @(posedge Clk); #5;
    rst_q.push_back(1'b1);
    Reset = 1'b0;
    tick(3);
    Reset = 1'b1;
    probe("idle_after_midreset", S_IDLE, 1'b0, 1'b0, 1'b0, 3'd0);
    frame();
    probe("idle_holds", S_IDLE, 1'b0, 1'b0, 1'b0, 3'd0);
    enemy_detect = 4'b0000;
    tick(2);
    done = 1'b1;
  end

endmodule
